// File: rtl/sub_serial_16bit.sv
// Nibble-serial 16-bit subtractor d = a - b - bin, one 4-bit slice per clock, LSB nibble first.
// Define SUB_SERIAL_FLAGS_EN to build the zero/neg/ovf status registers; otherwise those ports read 0.
module sub_serial_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] d,
    output logic        bout,
    output logic        zero,
    output logic        neg,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_idx;
    logic        r_borrow;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [11:0] r_res;

    logic        w_accept;
    logic        w_last;
    logic [3:0]  w_an;
    logic [3:0]  w_bn;
    logic [4:0]  w_sum;
    logic [3:0]  w_n;
    logic        w_c;
    logic [15:0] w_d_full;

    // Subtraction as a + ~b + ~borrow; the slice carry is the inverted borrow.
    assign w_an     = r_a[{r_idx, 2'b00} +: 4];
    assign w_bn     = r_b[{r_idx, 2'b00} +: 4];
    assign w_sum    = {1'b0, w_an} + {1'b0, ~w_bn} + {4'b0000, ~r_borrow};
    assign w_n      = w_sum[3:0];
    assign w_c      = w_sum[4];
    assign w_d_full = {w_n, r_res};

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == 2'd3) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_borrow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx    <= 2'd0;
                r_borrow <= bin;
            end else if (r_state == S_RUN) begin
                r_idx    <= r_idx + 2'd1;
                r_borrow <= ~w_c;
            end
        end
    end

    // Operand and partial-result storage carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
        if (r_state == S_RUN) begin
            r_res <= {w_n, r_res[11:4]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= 16'h0000;
            bout <= 1'b0;
        end else if (w_last) begin
            d    <= w_d_full;
            bout <= ~w_c;
        end
    end

`ifdef SUB_SERIAL_FLAGS_EN
    logic r_zero;
    logic r_neg;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_zero <= (w_d_full == 16'h0000);
            r_neg  <= w_n[3];
            r_ovf  <= (r_a[15] ^ r_b[15]) & (w_n[3] ^ r_a[15]);
        end
    end

    assign zero = r_zero;
    assign neg  = r_neg;
    assign ovf  = r_ovf;
`else
    assign zero = 1'b0;
    assign neg  = 1'b0;
    assign ovf  = 1'b0;
`endif

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_sub_serial_16bit.sv
// Directed-vector bench for sub_serial_16bit; flag expectations follow SUB_SERIAL_FLAGS_EN.
module tb_sub_serial_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;

    int n_chk;
    int n_pass;
    int done_seen;

    sub_serial_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .zero  (zero),
        .neg   (neg),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fe(input logic v);
`ifdef SUB_SERIAL_FLAGS_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [15:0] ed, input logic eb,
                              input logic ez, input logic en, input logic eo);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".d"},    {16'd0, d},    {16'd0, ed});
        chk({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
        chk({tag, ".flags"}, {29'd0, zero, neg, ovf}, {29'd0, fe(ez), fe(en), fe(eo)});
    endtask

    // Full operation from IDLE: start at E0, result checked at E4, back to idle at E5.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vbin, input logic [15:0] ed, input logic eb,
                          input logic ez, input logic en, input logic eo);
        @(negedge clk);
        a = va; b = vb; bin = vbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
        chk({tag, ".busyE0"}, {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".busyE3"}, {30'd0, busy, done}, 32'd2);
        @(posedge clk); #1;
        chk_result(tag, ed, eb, ez, en, eo);
        @(posedge clk); #1;
        chk({tag, ".idleE5"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ctl", {30'd0, busy, done}, 32'd0);
        chk("reset.d", {13'd0, d, bout, zero, neg, ovf}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("chain",  16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("wrap",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("ovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("zero",   16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // start held through RUN with different operands must not disturb the result
        @(negedge clk);
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("hold.d_during_run", {16'd0, d}, 32'h0000);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        chk_result("hold", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-to-back: new start accepted in the DONE cycle
        @(negedge clk);
        a = 16'h0003; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.busy", {30'd0, busy, done}, 32'd2);
        chk("b2b.d_held", {16'd0, d}, 32'h1000);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b.busyE3", {30'd0, busy, done}, 32'd2);
        @(posedge clk); #1;
        chk_result("b2b", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset during RUN aborts with no done pulse
        @(negedge clk);
        a = 16'h0000; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.ctl", {30'd0, busy, done}, 32'd0);
        chk("abort.out", {13'd0, d, bout, zero, neg, ovf}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("abort.no_done", done_seen, 0);
        run_op("after_abort", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
